// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: APB-programmed 8-digit multiplexed seven-segment scanner
// with per-digit blanking gap, digit masking and an end-of-frame tick.
module seg_scan_ctrl #(
    parameter int                DIV_W      = 16,
    parameter logic [DIV_W-1:0]  DIV_RESET  = DIV_W'(50000),
    parameter int                GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    input  logic [7:0]  seg_in_0,
    input  logic [7:0]  seg_in_1,
    input  logic [7:0]  seg_in_2,
    input  logic [7:0]  seg_in_3,
    input  logic [7:0]  seg_in_4,
    input  logic [7:0]  seg_in_5,
    input  logic [7:0]  seg_in_6,
    input  logic [7:0]  seg_in_7,
    output logic [7:0]  scan_an,
    output logic [7:0]  scan_seg,
    output logic        frame_tick
);
    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_e;

    state_e           state_q;
    logic             en_q, en_d;
    logic [7:0]       mask_q, mask_d;
    logic [DIV_W-1:0] div_q, div_d, div_eff, cnt_q;
    logic [2:0]       idx_q, idx_nx;
    logic [7:0]       hold_q;
    logic             tick_q;
    logic             acc, a_ctrl, a_div, a_stat, err, wr;
    logic [31:0]      wmask;
    logic [7:0]       seg_arr [8];
    logic             unused_ok;

    assign seg_arr = '{seg_in_0, seg_in_1, seg_in_2, seg_in_3,
                       seg_in_4, seg_in_5, seg_in_6, seg_in_7};

    assign acc    = in_psel & in_penable;
    assign a_ctrl = in_paddr[3:0] == 4'h0;
    assign a_div  = in_paddr[3:0] == 4'h4;
    assign a_stat = in_paddr[3:0] == 4'h8;
    assign err    = acc & (~(a_ctrl | a_div | a_stat) | (a_stat & in_pwrite));
    assign wr     = acc & in_pwrite & ~err;
    assign wmask  = {{8{in_pstrb[3]}}, {8{in_pstrb[2]}}, {8{in_pstrb[1]}}, {8{in_pstrb[0]}}};

    assign in_pready  = acc;
    assign in_pslverr = err;
    assign in_prdata  = !acc   ? 32'h0 :
                        a_ctrl ? {16'h0, mask_q, 7'h0, en_q} :
                        a_div  ? 32'(div_q) :
                        a_stat ? {23'h0, state_q != IDLE, 5'h0, idx_q} : 32'h0;

    assign unused_ok = ^{in_pprot, in_paddr[31:4], in_pwdata, in_pstrb, wmask};

    always_comb begin
        en_d   = (wr & a_ctrl & in_pstrb[0]) ? in_pwdata[0] : en_q;
        mask_d = (wr & a_ctrl & in_pstrb[1]) ? in_pwdata[15:8] : mask_q;
        div_d  = (wr & a_div) ? ((div_q & ~wmask[DIV_W-1:0]) | (in_pwdata[DIV_W-1:0] & wmask[DIV_W-1:0]))
                              : div_q;
    end

    assign div_eff = (div_q == '0) ? DIV_W'(1) : div_q;
    assign idx_nx  = idx_q + 3'd1;

    // Outputs decode registered state only, so a mask write shows up one cycle after commit.
    assign scan_an    = (state_q == SHOW && !mask_q[idx_q]) ? ~(8'h01 << idx_q) : 8'hFF;
    assign scan_seg   = (state_q == SHOW) ? hold_q : 8'hFF;
    assign frame_tick = tick_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            mask_q  <= 8'h00;
            div_q   <= DIV_RESET;
            idx_q   <= 3'd0;
            cnt_q   <= '0;
            hold_q  <= 8'hFF;
            tick_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            mask_q <= mask_d;
            div_q  <= div_d;
            tick_q <= 1'b0;
            case (state_q)
                IDLE: if (en_q) begin
                    state_q <= SHOW;
                    idx_q   <= 3'd0;
                    cnt_q   <= div_eff;
                    hold_q  <= seg_arr[0];
                end
                SHOW: if (!en_q) begin
                    state_q <= IDLE;
                    idx_q   <= 3'd0;
                end else if (cnt_q <= DIV_W'(1)) begin
                    state_q <= GAP;
                    cnt_q   <= DIV_W'(GAP_CYCLES);
                end else begin
                    cnt_q <= cnt_q - DIV_W'(1);
                end
                GAP: if (!en_q) begin
                    state_q <= IDLE;
                    idx_q   <= 3'd0;
                end else if (cnt_q <= DIV_W'(1)) begin
                    state_q <= SHOW;
                    idx_q   <= idx_nx;
                    cnt_q   <= div_eff;
                    hold_q  <= seg_arr[idx_nx];
                    tick_q  <= idx_q == 3'd7;
                end else begin
                    cnt_q <= cnt_q - DIV_W'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed and randomized checks of seg_scan_ctrl against
// a schedule-based reference model (digit windows computed from start cycle).
module tb_seg_scan_ctrl;
    localparam int          G    = 2;
    localparam logic [15:0] DRST = 16'd50000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] in_paddr, in_pwdata, in_prdata;
    logic        in_psel, in_penable, in_pwrite, in_pready, in_pslverr;
    logic [2:0]  in_pprot;
    logic [3:0]  in_pstrb;
    logic [7:0]  seg_in [8];
    logic [7:0]  scan_an, scan_seg;
    logic        frame_tick;

    seg_scan_ctrl dut (
        .clock(clock), .reset(reset),
        .in_paddr(in_paddr), .in_psel(in_psel), .in_penable(in_penable),
        .in_pprot(in_pprot), .in_pwrite(in_pwrite), .in_pwdata(in_pwdata),
        .in_pstrb(in_pstrb), .in_pready(in_pready), .in_prdata(in_prdata),
        .in_pslverr(in_pslverr),
        .seg_in_0(seg_in[0]), .seg_in_1(seg_in[1]), .seg_in_2(seg_in[2]), .seg_in_3(seg_in[3]),
        .seg_in_4(seg_in[4]), .seg_in_5(seg_in[5]), .seg_in_6(seg_in[6]), .seg_in_7(seg_in[7]),
        .scan_an(scan_an), .scan_seg(scan_seg), .frame_tick(frame_tick)
    );

    initial forever #5 clock = ~clock;

    int n_cmp = 0, n_bad = 0;

    // Model: digit m_dig shows during [m_start, m_start+m_len), then G gap cycles.
    bit          m_known = 0, m_en = 0, m_act = 0, m_tick = 0;
    logic [7:0]  m_mask = 0, m_pat = 8'hFF;
    logic [15:0] m_div = DRST;
    int          m_dig = 0, m_start = 0, m_len = 1, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit in_show();
        return m_act && (cyc - m_start) < m_len;
    endfunction

    function automatic bit in_gap();
        return m_act && (cyc - m_start) >= m_len;
    endfunction

    task automatic m_begin(input int d);
        m_act   = 1;
        m_dig   = d;
        m_start = cyc + 1;
        m_len   = (m_div == 0) ? 1 : int'(m_div);
        m_pat   = seg_in[d];
    endtask

    task automatic cycle();
        logic [7:0]  e_an;
        logic [31:0] e_rd;
        logic [3:0]  a;
        bit          acc, err, en_c;
        #1;
        a   = in_paddr[3:0];
        acc = in_psel && in_penable;
        err = acc && (!(a == 4'h0 || a == 4'h4 || a == 4'h8) || (a == 4'h8 && in_pwrite));
        e_rd = 32'h0;
        if (acc && a == 4'h0) e_rd = {16'h0, m_mask, 7'h0, m_en};
        if (acc && a == 4'h4) e_rd = {16'h0, m_div};
        if (acc && a == 4'h8) e_rd = {23'h0, m_act, 5'h0, 3'(m_dig)};
        e_an = 8'hFF;
        if (in_show() && !m_mask[m_dig]) e_an = ~(8'h01 << m_dig);
        if (m_known) begin
            chk("scan_an", scan_an, e_an);
            chk("scan_seg", scan_seg, in_show() ? m_pat : 8'hFF);
            chk("frame_tick", frame_tick, m_tick);
            chk("an_onehot", $countones(~scan_an) <= 1, 1);
            chk("pready", in_pready, acc);
            chk("pslverr", in_pslverr, err);
            chk("prdata", in_prdata, e_rd);
        end
        if (reset) begin
            m_known = 1; m_en = 0; m_mask = 0; m_div = DRST;
            m_act = 0; m_dig = 0; m_tick = 0;
        end else begin
            en_c   = m_en;
            m_tick = 0;
            if (!m_act) begin
                if (en_c) m_begin(0);
            end else if (!en_c) begin
                m_act = 0;
                m_dig = 0;
            end else if (cyc - m_start + 1 == m_len + G) begin
                m_tick = (m_dig == 7);
                m_begin((m_dig + 1) % 8);
            end
            if (acc && in_pwrite && !err) begin
                if (a == 4'h0 && in_pstrb[0]) m_en = in_pwdata[0];
                if (a == 4'h0 && in_pstrb[1]) m_mask = in_pwdata[15:8];
                if (a == 4'h4 && in_pstrb[0]) m_div[7:0] = in_pwdata[7:0];
                if (a == 4'h4 && in_pstrb[1]) m_div[15:8] = in_pwdata[15:8];
            end
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic apb(input logic [31:0] addr, input bit wr, input logic [31:0] data, input logic [3:0] strb);
        in_paddr = addr; in_pwrite = wr; in_pwdata = data; in_pstrb = strb;
        in_psel = 1; in_penable = 1;
        cycle();
        in_psel = 0; in_penable = 0; in_pwrite = 0;
    endtask

    // kind 0: SHOW of digit d; 1: any GAP cycle; 2: last GAP cycle of digit 7
    task automatic wait_for(input string tag, input int kind, input int d);
        bit found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            if ((kind == 0 && in_show() && m_dig == d) || (kind == 1 && in_gap()) ||
                (kind == 2 && in_gap() && m_dig == 7 && cyc - m_start + 1 == m_len + G))
                found = 1;
            else
                cycle();
        end
        chk(tag, found, 1);
    endtask

    initial begin
        int last;
        logic [31:0] ad;
        reset = 1; in_paddr = 0; in_psel = 0; in_penable = 0; in_pprot = 0;
        in_pwrite = 0; in_pwdata = 0; in_pstrb = 0;
        for (int i = 0; i < 8; i++) seg_in[i] = 8'($urandom);
        @(negedge clock);
        repeat (3) cycle();
        reset = 0;
        cycle();
        apb(32'h0, 0, 0, 0);
        apb(32'h4, 0, 0, 0);
        apb(32'h8, 0, 0, 0);
        // basic scan
        seg_in[0] = 8'h03;
        apb(32'h4, 1, 32'd4, 4'hF);
        apb(32'h0, 1, 32'h1, 4'hF);
        repeat (20) cycle();
        // frame timing with STATUS polling
        apb(32'h0, 1, 32'h0, 4'hF);
        repeat (3) cycle();
        apb(32'h0, 1, 32'h1, 4'hF);
        last = -1;
        for (int i = 0; i < 150; i++) begin
            apb(32'h8, 0, 0, 0);
            if (frame_tick === 1'b1) begin
                if (last >= 0) chk("frame_period", cyc - last, 48);
                last = cyc;
            end
        end
        chk("frame_seen", last >= 0, 1);
        // mask digits 0 and 2
        apb(32'h0, 1, 32'h0501, 4'hF);
        repeat (60) cycle();
        // mid-operation disable in digit 3
        wait_for("wait_show3", 0, 3);
        apb(32'h0, 1, 32'h0, 4'hF);
        repeat (2) cycle();
        apb(32'h8, 0, 0, 0);
        // error path
        apb(32'hC, 0, 0, 0);
        apb(32'h8, 1, 32'hFFFF_FFFF, 4'hF);
        apb(32'hC, 1, 32'hFFFF_FFFF, 4'hF);
        apb(32'h0, 0, 0, 0);
        apb(32'h4, 0, 0, 0);
        // DIV = 0 gives one-cycle SHOW; partial strobe writes
        apb(32'h4, 1, 32'h0, 4'hF);
        apb(32'h0, 1, 32'h1, 4'hF);
        repeat (30) cycle();
        apb(32'h4, 1, 32'h0000_0203, 4'h1);
        apb(32'h4, 0, 0, 0);
        // disable coincident with frame wrap: tick still emitted
        wait_for("wait_wrap", 2, 7);
        apb(32'h0, 1, 32'h0, 4'h1);
        repeat (4) cycle();
        apb(32'h0, 1, 32'h1, 4'h1);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            for (int k = 0; k < 8; k++) if ($urandom_range(0, 3) == 0) seg_in[k] = 8'($urandom);
            reset = ($urandom_range(0, 299) == 0);
            in_pprot = 3'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 4))
                    0: ad = 32'h0;
                    1: ad = 32'h4;
                    2: ad = 32'h8;
                    3: ad = 32'hC;
                    default: ad = $urandom;
                endcase
                apb(ad, 1'($urandom), (ad[3:0] == 4'h4) ? 32'($urandom_range(0, 6))
                    : {$urandom_range(0, 255) << 8} | 32'($urandom_range(0, 7) != 0), 4'($urandom));
            end else begin
                cycle();
            end
        end
        reset = 0;
        // reset during GAP with a simultaneous CTRL write
        apb(32'h4, 1, 32'd3, 4'hF);
        apb(32'h0, 1, 32'h1, 4'hF);
        wait_for("wait_gap", 1, 0);
        reset = 1;
        apb(32'h0, 1, 32'h0301, 4'hF);
        reset = 0;
        apb(32'h0, 0, 0, 0);
        apb(32'h4, 0, 0, 0);
        apb(32'h8, 0, 0, 0);
        repeat (5) cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
